// File: rtl/atcbmc200_rspmux.sv
// AHB bus-matrix data-phase response mux with embedded default slave and
// sticky decode-error capture register.
module atcbmc200_rspmux #(
  parameter int NSLV       = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic [NSLV-1:0]            hsel_vec,
  input  logic [1:0]                 htrans,
  input  logic [ADDR_WIDTH-1:0]      haddr,
  input  logic                       hwrite,
  input  logic [NSLV*DATA_WIDTH-1:0] s_hrdata,
  input  logic [NSLV-1:0]            s_hreadyout,
  input  logic [NSLV-1:0]            s_hresp,
  output logic [DATA_WIDTH-1:0]      hrdata,
  output logic                       hready,
  output logic                       hresp,
  output logic                       err_valid,
  output logic                       err_ovf,
  output logic [ADDR_WIDTH-1:0]      err_addr,
  output logic                       err_write,
  input  logic                       err_clr
);

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_t;

  localparam logic [NSLV-1:0] ONE = NSLV'(1);

  ds_state_t       ds_state, ds_next;
  logic [NSLV-1:0] dp_sel;
  logic            active, onehot, bad_dec, accept;
  logic            sel_ready, sel_resp;

  assign active  = htrans[1];
  assign onehot  = (hsel_vec != '0) && ((hsel_vec & (hsel_vec - ONE)) == '0);
  assign bad_dec = active && !onehot;
  assign accept  = hready;

  // dp_sel is one-hot or zero, so OR-reducing the masked slave signals is a mux.
  always_comb begin
    hrdata    = '0;
    sel_ready = |(dp_sel & s_hreadyout);
    sel_resp  = |(dp_sel & s_hresp);
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (dp_sel[i]) begin
        hrdata = hrdata | s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (|dp_sel) begin
      hready = sel_ready;
      hresp  = sel_resp;
    end else begin
      unique case (ds_state)
        DS_ERR1: begin hready = 1'b0; hresp = 1'b1; end
        DS_ERR2: begin hready = 1'b1; hresp = 1'b1; end
        default: begin hready = 1'b1; hresp = 1'b0; end
      endcase
    end
  end

  always_comb begin
    ds_next = ds_state;
    unique case (ds_state)
      DS_ERR1: ds_next = DS_ERR2;
      default: begin
        if (accept) begin
          ds_next = bad_dec ? DS_ERR1 : DS_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ds_state <= DS_IDLE;
      dp_sel   <= '0;
    end else begin
      ds_state <= ds_next;
      if (accept) begin
        dp_sel <= (active && !bad_dec) ? hsel_vec : '0;
      end
    end
  end

  // A clear coinciding with a new capture behaves as clear-then-capture.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_valid <= 1'b0;
      err_ovf   <= 1'b0;
      err_addr  <= '0;
      err_write <= 1'b0;
    end else if (accept && bad_dec) begin
      if (!err_valid || err_clr) begin
        err_valid <= 1'b1;
        err_ovf   <= 1'b0;
        err_addr  <= haddr;
        err_write <= hwrite;
      end else begin
        err_ovf <= 1'b1;
      end
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_atcbmc200_rspmux.sv
// Bench for atcbmc200_rspmux: directed vector table, reset corner case, and
// randomized traffic against a transaction-level reference model.
module tb_atcbmc200_rspmux;

  localparam int NSLV = 8;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam logic [31:0] D2 = 32'hA5A5_0001;
  localparam logic [31:0] D7 = 32'h3C00_0007;

  logic               hclk, hresetn;
  logic [NSLV-1:0]    hsel_vec;
  logic [1:0]         htrans;
  logic [AW-1:0]      haddr;
  logic               hwrite;
  logic [NSLV*DW-1:0] s_hrdata;
  logic [NSLV-1:0]    s_hreadyout, s_hresp;
  logic [DW-1:0]      hrdata;
  logic               hready, hresp, err_valid, err_ovf, err_write, err_clr;
  logic [AW-1:0]      err_addr;

  int errors = 0;
  int checks = 0;

  atcbmc200_rspmux #(.NSLV(NSLV), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel_vec(hsel_vec), .htrans(htrans),
    .haddr(haddr), .hwrite(hwrite), .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout),
    .s_hresp(s_hresp), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .err_valid(err_valid), .err_ovf(err_ovf), .err_addr(err_addr),
    .err_write(err_write), .err_clr(err_clr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [1:0]  trans;
    logic [7:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  rdy;
    logic [7:0]  resp;
    logic        clr;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    logic        e_ev;
    logic        e_eo;
    logic [31:0] e_addr;
    logic        e_ew;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rdy, input logic e_resp,
                         input logic [31:0] e_data, input logic e_ev, input logic e_eo,
                         input logic [31:0] e_addr, input logic e_ew);
    chk({tag, ".hready"},    32'(hready),    32'(e_rdy));
    chk({tag, ".hresp"},     32'(hresp),     32'(e_resp));
    chk({tag, ".hrdata"},    hrdata,         e_data);
    chk({tag, ".err_valid"}, 32'(err_valid), 32'(e_ev));
    chk({tag, ".err_ovf"},   32'(err_ovf),   32'(e_eo));
    chk({tag, ".err_addr"},  err_addr,       e_addr);
    chk({tag, ".err_write"}, 32'(err_write), 32'(e_ew));
  endtask

  function automatic logic [31:0] slave_word(input int i);
    return (i == 2) ? D2 : 32'h3C00_0000 + 32'(i);
  endfunction

  // Reference model state: who owns the data phase, how many error-response
  // cycles have elapsed, and how many decode errors since the last clear.
  int          m_owner;
  int          m_errcyc;
  int          m_cnt;
  logic [31:0] m_addr;
  logic        m_wr;

  initial begin
    vecs[0]  = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{2'b10, 8'h04, 32'h0000_2000, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFB, 8'h00, 1'b0, 1'b0, 1'b0, D2,    1'b0, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFB, 8'h00, 1'b0, 1'b0, 1'b0, D2,    1'b0, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFB, 8'h00, 1'b0, 1'b0, 1'b0, D2,    1'b0, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, D2,    1'b0, 1'b0, 32'h0,         1'b0};
    vecs[6]  = '{2'b10, 8'h00, 32'h8000_0010, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[7]  = '{2'b10, 8'h00, 32'h0000_1234, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h8000_0010, 1'b1};
    vecs[8]  = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h8000_0010, 1'b1};
    vecs[9]  = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8000_0010, 1'b1};
    vecs[10] = '{2'b10, 8'h00, 32'h0000_0100, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0010, 1'b1};
    vecs[11] = '{2'b10, 8'h00, 32'h0000_DEAD, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 1'b0};
    vecs[12] = '{2'b10, 8'h00, 32'h0000_0200, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 1'b0};
    vecs[13] = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 1'b0};
    vecs[14] = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 1'b0};
    vecs[15] = '{2'b10, 8'h03, 32'h0000_0300, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 1'b0};
    vecs[16] = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 1'b0};
    vecs[17] = '{2'b01, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 1'b0};
    vecs[18] = '{2'b01, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 1'b0};
    vecs[19] = '{2'b11, 8'h80, 32'h0000_0700, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 1'b0};
    vecs[20] = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b1, D7,    1'b1, 1'b0, 32'h0000_0300, 1'b0};
    vecs[21] = '{2'b00, 8'h00, 32'h0,         1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 1'b0};

    hresetn = 1'b0; htrans = 2'b00; hsel_vec = '0; haddr = '0; hwrite = 1'b0;
    s_hreadyout = '1; s_hresp = '0; err_clr = 1'b0;
    for (int i = 0; i < NSLV; i++) s_hrdata[i*DW +: DW] = slave_word(i);

    repeat (2) @(negedge hclk);
    #1 chk_all("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge hclk);
    hresetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge hclk);
      htrans = vecs[i].trans; hsel_vec = vecs[i].sel; haddr = vecs[i].addr;
      hwrite = vecs[i].wr; s_hreadyout = vecs[i].rdy; s_hresp = vecs[i].resp;
      err_clr = vecs[i].clr;
      #1 chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_resp, vecs[i].e_data,
                 vecs[i].e_ev, vecs[i].e_eo, vecs[i].e_addr, vecs[i].e_ew);
    end

    // Reset pulled while the default slave is in its first ERROR cycle.
    @(negedge hclk);
    htrans = 2'b10; hsel_vec = '0; haddr = 32'h40; hwrite = 1'b0; err_clr = 1'b0;
    s_hreadyout = '1; s_hresp = '0;
    @(negedge hclk);
    htrans = 2'b00;
    #1 chk("rst_err1.pre_hready", 32'(hready), 32'h0);
    hresetn = 1'b0;
    #1 chk("rst_err1.hready", 32'(hready), 32'h1);
    chk("rst_err1.hresp", 32'(hresp), 32'h0);
    chk("rst_err1.err_valid", 32'(err_valid), 32'h0);
    @(negedge hclk);
    hresetn = 1'b1; htrans = 2'b10; hsel_vec = 8'h01;
    @(negedge hclk);
    htrans = 2'b00; hsel_vec = '0;
    #1 chk_all("rst_err1.good", 1'b1, 1'b0, slave_word(0), 1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic against the reference model.
    @(negedge hclk);
    hresetn = 1'b0;
    m_owner = -1; m_errcyc = 0; m_cnt = 0; m_addr = '0; m_wr = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      logic        e_rdy, e_resp, bad, acc;
      logic [31:0] e_data;
      int          r;
      @(negedge hclk);
      htrans = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r < 2) hsel_vec = '0;
      else if (r == 2) hsel_vec = 8'($urandom);
      else hsel_vec = 8'd1 << $urandom_range(0, 7);
      haddr = $urandom; hwrite = 1'($urandom);
      for (int i = 0; i < NSLV; i++) begin
        s_hrdata[i*DW +: DW] = $urandom;
        s_hreadyout[i] = ($urandom_range(0, 3) != 0);
        s_hresp[i] = ($urandom_range(0, 7) == 0);
      end
      err_clr = ($urandom_range(0, 9) == 0);
      #1;
      if (m_owner >= 0) begin
        e_rdy = s_hreadyout[m_owner]; e_resp = s_hresp[m_owner];
        e_data = s_hrdata[m_owner*DW +: DW];
      end else begin
        e_rdy = (m_errcyc != 1); e_resp = (m_errcyc != 0); e_data = '0;
      end
      chk_all($sformatf("rand%0d", n), e_rdy, e_resp, e_data, m_cnt >= 1, m_cnt >= 2, m_addr, m_wr);

      bad = htrans[1] && ($countones(hsel_vec) != 1);
      acc = e_rdy;
      if (m_errcyc == 1) m_errcyc = 2;
      else if (acc) begin
        m_errcyc = bad ? 1 : 0;
        m_owner = -1;
        if (htrans[1] && !bad)
          for (int i = 0; i < NSLV; i++) if (hsel_vec[i]) m_owner = i;
      end
      if (acc && bad) begin
        if (err_clr) m_cnt = 0;
        m_cnt++;
        if (m_cnt == 1) begin m_addr = haddr; m_wr = hwrite; end
      end else if (err_clr) m_cnt = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
